// File: rtl/spi_nx_pkg.sv
// Shared state encoding and SPI mode constants for the spi_master_nx block.
package spi_nx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD
  } spi_state_e;

  // Mode encoding is {cpol, cpha}.
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_nx_clkgen.sv
// Half-period tick generator with leading/trailing SCLK edge strobes.
module spi_nx_clkgen #(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic xfer,
  output logic tick,
  output logic lead,
  output logic trail
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] cnt_q;
  logic             half_q;

  assign tick  = run && (cnt_q == CNT_W'(CLK_DIV - 1));
  // First half of each SCLK period sits at idle level; the toggle lands on its tick.
  assign lead  = tick && xfer && !half_q;
  assign trail = tick && xfer && half_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      half_q <= 1'b0;
    end else begin
      if (!run || tick) cnt_q <= '0;
      else              cnt_q <= cnt_q + 1'b1;
      if (!xfer)     half_q <= 1'b0;
      else if (tick) half_q <= !half_q;
    end
  end

endmodule

// File: rtl/spi_master_nx.sv
// SPI master, all four modes, NUM_CS selects. Define SPI_MASTER_NX_LOOPBACK_EN to add
// a loopback input that feeds the receive shifter from mosi instead of miso.
module spi_master_nx
  import spi_nx_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned CLK_DIV = 16,
  parameter int unsigned NUM_CS  = 2,
  localparam int unsigned CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              ready,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [DATA_W-1:0] data_tx,
  output logic [DATA_W-1:0] data_rx,
  output logic              rx_valid,
  output logic              busy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
`ifdef SPI_MASTER_NX_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic [NUM_CS-1:0] cs_n
);

  spi_state_e state_q, state_d;

  logic [DATA_W-1:0] tx_q, rx_q, data_rx_q;
  logic [NUM_CS-1:0] cs_n_q, sel_n;
  logic [5:0]        bit_q;
  logic              cpol_q, cpha_q, sclk_q, mosi_q, rx_valid_q;
  logic              miso_meta_q, miso_sync_q;
  logic [31:0]       cs_sel_ext;
  logic              tick, lead, trail, accept, xfer_done, hold_done;
  logic              shift_en, sample_en, rx_bit;

  spi_nx_clkgen #(
    .CLK_DIV(CLK_DIV)
  ) u_clkgen (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (state_q != IDLE),
    .xfer (state_q == XFER),
    .tick (tick),
    .lead (lead),
    .trail(trail)
  );

  assign cs_sel_ext = 32'(cs_sel);
  assign ready      = (state_q == IDLE) && !rx_valid_q;
  assign busy       = !ready;
  assign accept     = start && ready && (cs_sel_ext < NUM_CS);
  assign xfer_done  = trail && (bit_q == 6'(DATA_W - 1));
  assign hold_done  = (state_q == HOLD) && tick;
  assign shift_en   = cpha_q ? lead : trail;
  assign sample_en  = cpha_q ? trail : lead;

`ifdef SPI_MASTER_NX_LOOPBACK_EN
  assign rx_bit = loopback ? mosi_q : miso_sync_q;
`else
  assign rx_bit = miso_sync_q;
`endif

  always_comb begin
    sel_n = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (cs_sel_ext == 32'(i)) sel_n[i] = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)    state_d = SETUP;
      SETUP:   if (tick)      state_d = XFER;
      XFER:    if (xfer_done) state_d = HOLD;
      HOLD:    if (tick)      state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q        <= '0;
      rx_q        <= '0;
      data_rx_q   <= '0;
      cs_n_q      <= '1;
      bit_q       <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      miso_meta_q <= 1'b0;
      miso_sync_q <= 1'b0;
    end else begin
      miso_meta_q <= miso;
      miso_sync_q <= miso_meta_q;
      rx_valid_q  <= 1'b0;
      if (accept) begin
        cpol_q <= cpol;
        cpha_q <= cpha;
        sclk_q <= cpol;
        cs_n_q <= sel_n;
        bit_q  <= '0;
        mosi_q <= data_tx[DATA_W-1];
        // cpha=0 already shows the MSB, so the shifter starts one bit ahead.
        tx_q   <= cpha ? data_tx : {data_tx[DATA_W-2:0], 1'b0};
      end
      if (lead || trail) sclk_q <= !sclk_q;
      if (shift_en) begin
        mosi_q <= tx_q[DATA_W-1];
        tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
      end
      if (sample_en) rx_q  <= {rx_q[DATA_W-2:0], rx_bit};
      if (trail)     bit_q <= bit_q + 6'd1;
      if (hold_done) begin
        cs_n_q     <= '1;
        data_rx_q  <= rx_q;
        rx_valid_q <= 1'b1;
        mosi_q     <= 1'b0;
      end
    end
  end

  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;
  assign data_rx  = data_rx_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_master_nx.sv
// Directed bench for spi_master_nx with a behavioural SPI slave on the pins.
module tb_spi_master_nx;
  import spi_nx_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, cpol = 1'b0, cpha = 1'b0, miso = 1'b0;
  logic [1:0]  cs_sel = '0;
  logic [15:0] data_tx = '0;
  logic [15:0] data_rx;
  logic        rx_valid, ready, busy, sclk, mosi;
  logic [2:0]  cs_n;
`ifdef SPI_MASTER_NX_LOOPBACK_EN
  logic        loopback = 1'b0;
`endif

  int n_pass = 0, n_total = 0;

  // Slave model state
  logic        slv_cpol = 1'b0, slv_cpha = 1'b0;
  logic [15:0] slv_word = '0, slv_rx = '0;
  logic [2:0]  cs_prev = 3'b111;
  logic        sclk_prev = 1'b0;
  int          idx = 0, rise_cnt = 0;

  spi_master_nx #(
    .DATA_W (16),
    .CLK_DIV(16),
    .NUM_CS (3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .ready   (ready),
    .cpol    (cpol),
    .cpha    (cpha),
    .cs_sel  (cs_sel),
    .data_tx (data_tx),
    .data_rx (data_rx),
    .rx_valid(rx_valid),
    .busy    (busy),
    .sclk    (sclk),
    .mosi    (mosi),
    .miso    (miso),
`ifdef SPI_MASTER_NX_LOOPBACK_EN
    .loopback(loopback),
`endif
    .cs_n    (cs_n)
  );

  always #5 clk = ~clk;

  always @(sclk or cs_n) begin
    if (cs_n != 3'b111 && cs_prev == 3'b111) begin
      idx    = 15;
      slv_rx = '0;
      miso   = slv_cpha ? 1'b0 : slv_word[15];
    end else if (cs_n != 3'b111 && sclk !== sclk_prev) begin
      if (sclk) rise_cnt++;
      // Sample on leading edge for cpha=0, trailing for cpha=1.
      if ((sclk != slv_cpol) != slv_cpha) begin
        slv_rx = {slv_rx[14:0], mosi};
      end else if (slv_cpha) begin
        if (idx >= 0) miso = slv_word[idx];
        idx--;
      end else begin
        idx--;
        if (idx >= 0) miso = slv_word[idx];
      end
    end
    cs_prev   = cs_n;
    sclk_prev = sclk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // Issue one request and follow it to cycle 546 (ready back up).
  task automatic run_frame(input string name, input logic [1:0] mode, input logic [1:0] sel,
                           input logic [2:0] exp_cs, input logic [15:0] tx, input logic [15:0] sw,
                           input logic [15:0] exp_rx, input int pulse_at, input bit keep_start);
    int   vcyc, nv, r0;
    logic cs_bad, rdy_v;
    slv_cpol = mode[1];
    slv_cpha = mode[0];
    slv_word = sw;
    r0       = rise_cnt;
    cpol     = mode[1];
    cpha     = mode[0];
    cs_sel   = sel;
    data_tx  = tx;
    start    = 1'b1;
    vcyc = 0; nv = 0; cs_bad = 1'b0; rdy_v = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= 546; cyc++) begin
      if (cyc > 1) begin
        @(posedge clk); #1;
      end
      start = keep_start || (cyc == pulse_at);
      if (rx_valid) begin
        nv++;
        if (vcyc == 0) begin
          vcyc  = cyc;
          rdy_v = ready;
        end
      end
      if (cyc <= 544 && cs_n !== exp_cs) cs_bad = 1'b1;
    end
    check({name, " rx_valid cycle"}, 32'(vcyc), 32'd545);
    check({name, " rx_valid count"}, 32'(nv), 32'd1);
    check({name, " ready during rx_valid"}, 32'(rdy_v), 32'd0);
    check({name, " cs_n held"}, 32'(cs_bad), 32'd0);
    check({name, " data_rx"}, 32'(data_rx), 32'(exp_rx));
    check({name, " mosi bits"}, 32'(slv_rx), 32'(tx));
    check({name, " sclk rising edges"}, 32'(rise_cnt - r0), 32'd16);
    check({name, " ready after"}, 32'(ready), 32'd1);
    check({name, " cs_n released"}, 32'(cs_n), 32'b111);
  endtask

  initial begin
    int   nv, cyc;
    logic flag;

    repeat (3) @(posedge clk);
    #1;
    check("reset ready", 32'(ready), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset cs_n", 32'(cs_n), 32'b111);
    check("reset sclk", 32'(sclk), 32'd0);
    check("reset mosi", 32'(mosi), 32'd0);
    check("reset data_rx", 32'(data_rx), 32'd0);
    check("reset rx_valid", 32'(rx_valid), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_frame("mode0", MODE0, 2'd0, 3'b110, 16'hA55A, 16'hA55A, 16'hA55A, 0, 1'b0);
    repeat (50) @(posedge clk);
    #1;
    check("data_rx hold", 32'(data_rx), 32'hA55A);

    run_frame("mode3", MODE3, 2'd0, 3'b110, 16'h5A0F, 16'h00C3, 16'h00C3, 0, 1'b0);
    check("mode3 sclk idle", 32'(sclk), 32'd1);

    // start pulsed mid-frame must be ignored
    run_frame("mode1 cs1", MODE1, 2'd1, 3'b101, 16'h8001, 16'h7E81, 16'h7E81, 100, 1'b0);
    nv = 0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (rx_valid) nv++;
    end
    check("no extra rx_valid", 32'(nv), 32'd0);

    // Out-of-range select: must stay idle, pins untouched
    cs_sel = 2'd3;
    cpol   = 1'b1;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    flag  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy !== 1'b0 || cs_n !== 3'b111 || rx_valid !== 1'b0) flag = 1'b1;
      @(posedge clk); #1;
    end
    check("reject stays idle", 32'(flag), 32'd0);
    check("reject ready", 32'(ready), 32'd1);
    check("reject sclk", 32'(sclk), 32'd0);

    // Back-to-back: start held high, second request taken as ready returns
    run_frame("mode2 b2b", MODE2, 2'd0, 3'b110, 16'hC3A5, 16'h5AA5, 16'h5AA5, 0, 1'b1);
    data_tx  = 16'h0F1E;
    slv_word = 16'hE1F0;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b busy", 32'(busy), 32'd1);
    check("b2b cs_n", 32'(cs_n), 32'b110);
    cyc = 1;
    while (!rx_valid && cyc < 700) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("b2b rx_valid cycle", 32'(cyc), 32'd545);
    check("b2b data_rx", 32'(data_rx), 32'hE1F0);
    check("b2b mosi bits", 32'(slv_rx), 32'h0F1E);
    @(posedge clk); #1;

    // Reset at cycle 200 of a mode-3 frame
    slv_cpol = 1'b1; slv_cpha = 1'b1; slv_word = 16'hFFFF;
    cpol = MODE3[1]; cpha = MODE3[0]; cs_sel = 2'd0; data_tx = 16'hFFFF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (199) @(posedge clk);
    #1;
    check("mid-frame busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort cs_n", 32'(cs_n), 32'b111);
    check("abort sclk", 32'(sclk), 32'd0);
    check("abort mosi", 32'(mosi), 32'd0);
    check("abort ready", 32'(ready), 32'd1);
    check("abort data_rx", 32'(data_rx), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (rx_valid) nv++;
    end
    check("abort no rx_valid", 32'(nv), 32'd0);
    check("abort sclk idle", 32'(sclk), 32'd0);

    run_frame("fresh", MODE0, 2'd1, 3'b101, 16'h3C96, 16'h0FF0, 16'h0FF0, 0, 1'b0);

`ifdef SPI_MASTER_NX_LOOPBACK_EN
    loopback = 1'b1;
    run_frame("loopback", MODE0, 2'd0, 3'b110, 16'h1234, 16'h0000, 16'h1234, 0, 1'b0);
    loopback = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
